block_check_arbiter: RTL and testbench
======================================

# block_check_arbiter

Round-robin scheduler that shares one begin/end nesting checker among `N_REQ` byte-stream requesters. It grants one requester per message, clears the checker before the message, and streams the message bytes into it one per cycle. It then samples the checker verdict after the last byte and returns a tagged verdict record. It sits between the text sources and the single checker instance; the checker has no enable, so this block owns every byte the checker sees.

## Interface
- `N_REQ`, default 4: number of requesters, ≥2.
- `LEN_W`, default 16: message-length counter width.
- `clk` in 1: clock.
- `reset` in 1: reset, asynchronous, active-high.
- `req_valid` in N_REQ: per-requester byte valid.
- `req_data` in N_REQ×8: per-requester byte, requester i at bits [8i+7:8i].
- `req_last` in N_REQ: byte is the final byte of its message.
- `req_ready` out N_REQ: byte accepted when `valid&ready`; at most one bit high.
- `chk_reset` out 1: clear pulse to the checker's reset.
- `chk_in` out 8: byte to the checker, sampled by it every edge.
- `chk_result` in 1: checker verdict (1 = balanced).
- `done_valid` out 1: one-cycle verdict strobe.
- `done_id` out clog2(N_REQ): requester index of the verdict.
- `done_pass` out 1: checker verdict, forced 0 when `done_err`.
- `done_err` out 1: message had an underrun (valid dropped mid-message).
- `done_len` out LEN_W: bytes accepted. Present only with `BLOCK_ARB_LEN_EN`.

## Operation
- FSM states: IDLE, CLR, STREAM, RESULT.
- **IDLE**
  - If any `req_valid` is high, latch grant = first requester with valid, searching from `last_grant+1` cyclically.
  - Set `last_grant` = grant, clear the err flag and length, and go to CLR.
- **CLR**
  - `chk_reset`=1 for exactly one cycle, then go to STREAM.
- **STREAM**
  - `req_ready[grant]`=1 and `chk_in` = `req_data[grant]` (combinational mux).
  - On each accepted byte, length increments, saturating at all-ones.
  - On an accepted byte with `req_last`, go to RESULT.
- **Underrun**
  - If `req_valid[grant]`=0 in STREAM, drive `chk_in`=0x20, set the err flag (sticky for this message), and stay in STREAM.
  - The requester must present a message contiguously; a gap inserts a word separator, so the verdict is flagged.
- **RESULT**
  - Sample `chk_result`.
  - At the leaving edge, register `done_*` and go to IDLE.
- **Filler byte**: in every state except an accepting STREAM cycle, `chk_in`=0x20 (ASCII space). The space is the neutral separator and never alters a completed count.
- **`chk_reset`** = `reset` OR (state==CLR), driven from a register OR'd with `reset`; the checker is cleared whenever this block is reset.
- **Other requesters**: `req_valid` of non-granted requesters is ignored until the grant returns to IDLE; no preemption.

## Timing
- **Reset values**
  - Outputs: `req_ready`=0, `chk_reset`=1 while `reset` is high, `chk_in`=0x20, `done_valid`=0, `done_id`=0, `done_pass`=0, `done_err`=0, `done_len`=0.
  - Internal: state=IDLE, `last_grant`=N_REQ-1, so requester 0 has first priority.
- **Message cycle count**: a gap-free L-byte message takes IDLE(1) + CLR(1) + L + RESULT(1) cycles.
- **Verdict strobe**: `done_valid` is high in the cycle after RESULT, which coincides with the next IDLE.
- **Back-to-back**: the next grant can be made in that same IDLE cycle, giving an L+3 cycle period.
- **First byte**: the first byte is accepted at the edge ending the first STREAM cycle, two edges after the grant edge.
- **RESULT sampling**: `chk_result` reflects all L bytes during the RESULT cycle. The space filler consumed at the RESULT edge does not affect the sampled value.
- **Reset mid-message**
  - Aborts without a `done_valid` strobe.
  - The aborted requester is expected to restart its message.
- **Simultaneous requests**: the round-robin rotation guarantees each persistently valid requester a grant within N_REQ messages.

## Configuration
- `BLOCK_ARB_LEN_EN` defined: the length counter and `done_len` port exist.
- `BLOCK_ARB_LEN_EN` undefined: neither the counter nor the port exists; all other behaviour is identical.

## Structure
- **Package `block_arb_pkg`**: FSM state enum, `ASCII_SPACE`=8'h20, default `LEN_W`.
- **Sub-module `rr_picker`**: combinational round-robin picker. Inputs: request vector, last grant. Outputs: grant index and any-request flag.

## Test plan
- **Basic pass**: req0 streams "begin end" (9 bytes, last on 'd').
  - `done_valid` at cycle 12 after the grant edge.
  - `done_id`=0, `done_pass`=1, `done_err`=0, `done_len`=9.
- **Unbalanced**: req1 streams "end begin" → `done_pass`=0, `done_id`=1.
- **Case-insensitive**: req2 streams "BeGiN eNd" → `done_pass`=1.
- **Rotation**: req0 and req2 are both valid from reset with repeated "begin end".
  - Verdict order is 0, 2, 0, 2.
  - Exactly one `req_ready` bit is high at a time.
- **Underrun**: req3 drops `req_valid` for 3 cycles after "beg", then sends "in end".
  - Result is `done_err`=1, `done_pass`=0, `done_len`=9.
  - `chk_in`=0x20 during the gap.
- **Reset mid-stream**: `reset` is pulsed during STREAM.
  - No `done_valid`; `req_ready`=0 and `chk_reset`=1 while `reset` is high.
  - A following "begin end" from req0 yields `done_pass`=1.

Source files
------------

// File: rtl/block_arb_pkg.sv
// Shared types and constants for the begin/end checker arbiter.
package block_arb_pkg;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_CLR    = 2'd1,
        ST_STREAM = 2'd2,
        ST_RESULT = 2'd3
    } arb_state_e;

    localparam logic [7:0]  ASCII_SPACE = 8'h20;
    localparam int unsigned DEF_LEN_W   = 16;

endpackage

// File: rtl/rr_picker.sv
// Combinational round-robin picker: first active request after the last grant.
module rr_picker #(
    parameter int unsigned N_REQ = 4
) (
    input  logic [N_REQ-1:0]         req,
    input  logic [$clog2(N_REQ)-1:0] last,
    output logic [$clog2(N_REQ)-1:0] grant,
    output logic                     any
);
    localparam int unsigned ID_W = $clog2(N_REQ);

    // Walk offsets from farthest to nearest so the nearest active request wins.
    always_comb begin
        int unsigned idx;
        idx   = 0;
        grant = '0;
        any   = |req;
        for (int unsigned off = N_REQ; off >= 1; off--) begin
            idx = (32'(last) + off) % N_REQ;
            if (req[ID_W'(idx)]) begin
                grant = ID_W'(idx);
            end
        end
    end

endmodule

// File: rtl/block_check_arbiter.sv
// Round-robin arbiter feeding one shared begin/end nesting checker, one message per grant.
// Optional length counter and done_len port enabled by defining BLOCK_ARB_LEN_EN.
module block_check_arbiter
    import block_arb_pkg::*;
#(
    parameter int unsigned N_REQ = 4,
    parameter int unsigned LEN_W = DEF_LEN_W
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic [N_REQ-1:0]         req_valid,
    input  logic [N_REQ*8-1:0]       req_data,
    input  logic [N_REQ-1:0]         req_last,
    output logic [N_REQ-1:0]         req_ready,
    output logic                     chk_reset,
    output logic [7:0]               chk_in,
    input  logic                     chk_result,
    output logic                     done_valid,
    output logic [$clog2(N_REQ)-1:0] done_id,
    output logic                     done_pass,
    output logic                     done_err
`ifdef BLOCK_ARB_LEN_EN
    ,
    output logic [LEN_W-1:0]         done_len
`endif
);
    localparam int unsigned ID_W = $clog2(N_REQ);

    if (N_REQ < 2 || LEN_W < 1) begin : g_bad_param
        $error("block_check_arbiter: N_REQ must be >= 2 and LEN_W >= 1");
    end

    arb_state_e      state;
    logic [ID_W-1:0] grant;
    logic [ID_W-1:0] last_grant;
    logic [ID_W-1:0] pick;
    logic            pick_any;
    logic            err;
    logic            clr_q;
    logic [7:0]      data_arr [N_REQ];
    logic            cur_valid;
    logic            cur_last;
    logic [7:0]      cur_data;
    logic            in_stream;
    logic            accept;

    rr_picker #(.N_REQ(N_REQ)) u_picker (
        .req   (req_valid),
        .last  (last_grant),
        .grant (pick),
        .any   (pick_any)
    );

    for (genvar i = 0; i < N_REQ; i++) begin : g_data
        assign data_arr[i] = req_data[8*i +: 8];
    end

    assign cur_valid = req_valid[grant];
    assign cur_last  = req_last[grant];
    assign cur_data  = data_arr[grant];
    assign in_stream = (state == ST_STREAM);
    assign accept    = in_stream & cur_valid;

    // Space is the neutral filler whenever no byte is being accepted.
    assign chk_in    = accept ? cur_data : ASCII_SPACE;
    assign chk_reset = clr_q | reset;

    always_comb begin
        req_ready = '0;
        if (in_stream) begin
            req_ready[grant] = 1'b1;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state      <= ST_IDLE;
            grant      <= '0;
            last_grant <= ID_W'(N_REQ - 1);
            err        <= 1'b0;
            clr_q      <= 1'b0;
            done_valid <= 1'b0;
            done_id    <= '0;
            done_pass  <= 1'b0;
            done_err   <= 1'b0;
        end else begin
            done_valid <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (pick_any) begin
                        grant      <= pick;
                        last_grant <= pick;
                        err        <= 1'b0;
                        clr_q      <= 1'b1;
                        state      <= ST_CLR;
                    end
                end
                ST_CLR: begin
                    clr_q <= 1'b0;
                    state <= ST_STREAM;
                end
                ST_STREAM: begin
                    // A gap feeds a separator to the checker, so the verdict is tainted.
                    if (!cur_valid) begin
                        err <= 1'b1;
                    end else if (cur_last) begin
                        state <= ST_RESULT;
                    end
                end
                ST_RESULT: begin
                    done_valid <= 1'b1;
                    done_id    <= grant;
                    done_pass  <= chk_result & ~err;
                    done_err   <= err;
                    state      <= ST_IDLE;
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

`ifdef BLOCK_ARB_LEN_EN
    logic [LEN_W-1:0] len_q;

    // Saturating count of accepted bytes for the current message.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            len_q    <= '0;
            done_len <= '0;
        end else begin
            if (state == ST_IDLE && pick_any) begin
                len_q <= '0;
            end else if (accept && !(&len_q)) begin
                len_q <= len_q + LEN_W'(1);
            end
            if (state == ST_RESULT) begin
                done_len <= len_q;
            end
        end
    end
`endif

endmodule

// File: tb/tb_block_check_arbiter.sv
// Directed bench for block_check_arbiter with a behavioural begin/end checker model.
module tb_block_check_arbiter;

    logic        clk;
    logic        reset;
    logic [3:0]  req_valid;
    logic [31:0] req_data;
    logic [3:0]  req_last;
    logic [3:0]  req_ready;
    logic        chk_reset;
    logic [7:0]  chk_in;
    logic        chk_result;
    logic        done_valid;
    logic [1:0]  done_id;
    logic        done_pass;
    logic        done_err;
`ifdef BLOCK_ARB_LEN_EN
    logic [15:0] done_len;
`endif

    block_check_arbiter dut (
        .clk        (clk),
        .reset      (reset),
        .req_valid  (req_valid),
        .req_data   (req_data),
        .req_last   (req_last),
        .req_ready  (req_ready),
        .chk_reset  (chk_reset),
        .chk_in     (chk_in),
        .chk_result (chk_result),
        .done_valid (done_valid),
        .done_id    (done_id),
        .done_pass  (done_pass),
        .done_err   (done_err)
`ifdef BLOCK_ARB_LEN_EN
        ,
        .done_len   (done_len)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // Checker model: words split on non-letters, case-insensitive, depth never below zero.
    typedef struct packed {
        logic [39:0] word;
        logic [7:0]  wlen;
        logic [7:0]  depth;
        logic        bad;
    } m_t;

    function automatic m_t finish_word(input m_t s);
        m_t r;
        r = s;
        if (r.wlen == 8'd5 && r.word == "begin") begin
            r.depth = r.depth + 8'd1;
        end else if (r.wlen == 8'd3 && r.word[23:0] == "end") begin
            if (r.depth == 8'd0) r.bad = 1'b1;
            else r.depth = r.depth - 8'd1;
        end
        r.wlen = 8'd0;
        r.word = '0;
        return r;
    endfunction

    function automatic m_t consume(input m_t s, input logic [7:0] c);
        m_t r;
        r = s;
        if ((c >= "a" && c <= "z") || (c >= "A" && c <= "Z")) begin
            r.word = {r.word[31:0], c | 8'h20};
            if (r.wlen != 8'hff) r.wlen = r.wlen + 8'd1;
        end else begin
            r = finish_word(r);
        end
        return r;
    endfunction

    m_t m;
    m_t m_fin;
    always @(posedge clk or posedge chk_reset) begin
        if (chk_reset) m <= '0;
        else m <= consume(m, chk_in);
    end
    assign m_fin      = finish_word(m);
    assign chk_result = !m_fin.bad && (m_fin.depth == 8'd0);

    typedef struct {
        int id;
        int pass;
        int err;
        int len;
        int cyc;
    } done_t;
    done_t dq[$];

    always @(negedge clk) begin
        if (done_valid === 1'b1) begin
`ifdef BLOCK_ARB_LEN_EN
            dq.push_back('{int'(done_id), int'(done_pass), int'(done_err), int'(done_len), cyc});
`else
            dq.push_back('{int'(done_id), int'(done_pass), int'(done_err), 0, cyc});
`endif
        end
    end

    int onehot_bad = 0;
    always @(negedge clk) begin
        if ($countones(req_ready) > 1) onehot_bad <= onehot_bad + 1;
    end

    int n_pass  = 0;
    int n_total = 0;
    int start_cyc [4];

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    endtask

    function automatic done_t get_done(input int k);
        done_t d;
        d = '{-1, -1, -1, -1, -1};
        if (k < dq.size()) d = dq[k];
        return d;
    endfunction

    // Present one message from requester id; optionally drop valid for gap_len stream cycles after gap_at bytes.
    task automatic send(input int id, input string s, input int gap_at, input int gap_len);
        int  i      = 0;
        int  g      = 0;
        int  budget = 0;
        bit  first  = 1'b1;
        while (i < s.len() && budget < 200) begin
            @(negedge clk);
            if (first) begin
                start_cyc[id] = cyc;
                first = 1'b0;
            end
            if (i == gap_at && g < gap_len) begin
                req_valid[id] = 1'b0;
                #1;
                check($sformatf("gap_chk_in_r%0d", id), 64'(chk_in), 64'h20);
                g++;
            end else begin
                req_valid[id]         = 1'b1;
                req_data[id*8 +: 8]   = s[i];
                req_last[id]          = (i == s.len() - 1);
                #1;
                if (req_ready[id]) begin
                    check($sformatf("byte_r%0d_%0d", id, i), 64'(chk_in), 64'(s[i]));
                    i++;
                end
            end
            budget++;
        end
        if (budget >= 200) check($sformatf("send_timeout_r%0d", id), 64'(i), 64'(s.len()));
        @(posedge clk);
        #1;
        req_valid[id] = 1'b0;
        req_last[id]  = 1'b0;
    endtask

    task automatic wait_done(input int n);
        int b = 0;
        while (dq.size() < n && b < 100) begin
            @(negedge clk);
            #2;
            b++;
        end
        check("done_seen", 64'(dq.size() >= n), 64'd1);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: bench did not finish");
        $fatal(1);
    end

    initial begin
        done_t d;
        int    nd;

        reset     = 1'b1;
        req_valid = '0;
        req_data  = '0;
        req_last  = '0;
        repeat (3) @(negedge clk);
        #1;
        check("rst_ready",      64'(req_ready),  64'h0);
        check("rst_chk_reset",  64'(chk_reset),  64'h1);
        check("rst_chk_in",     64'(chk_in),     64'h20);
        check("rst_done_valid", 64'(done_valid), 64'h0);
        check("rst_done_id",    64'(done_id),    64'h0);
        check("rst_done_pass",  64'(done_pass),  64'h0);
        check("rst_done_err",   64'(done_err),   64'h0);
`ifdef BLOCK_ARB_LEN_EN
        check("rst_done_len",   64'(done_len),   64'h0);
`endif
        reset = 1'b0;

        // Rotation: req0 and req2 contend from reset.
        fork
            begin send(0, "begin end", -1, 0); send(0, "begin end", -1, 0); end
            begin send(2, "begin end", -1, 0); send(2, "begin end", -1, 0); end
        join
        wait_done(4);
        check("rot_id0", 64'(get_done(0).id), 64'd0);
        check("rot_id1", 64'(get_done(1).id), 64'd2);
        check("rot_id2", 64'(get_done(2).id), 64'd0);
        check("rot_id3", 64'(get_done(3).id), 64'd2);
        for (int k = 0; k < 4; k++) check($sformatf("rot_pass%0d", k), 64'(get_done(k).pass), 64'd1);

        // Basic pass with cycle-exact timing and CLR pulse.
        nd = dq.size();
        fork
            send(0, "begin end", -1, 0);
            begin
                @(negedge clk); #2;
                check("idle_chk_reset", 64'(chk_reset), 64'd0);
                @(negedge clk); #2;
                check("clr_chk_reset", 64'(chk_reset), 64'd1);
                check("clr_ready", 64'(req_ready), 64'h0);
                @(negedge clk); #2;
                check("stream_chk_reset", 64'(chk_reset), 64'd0);
                check("stream_ready", 64'(req_ready), 64'h1);
            end
        join
        wait_done(nd + 1);
        d = get_done(nd);
        check("basic_id",   64'(d.id),   64'd0);
        check("basic_pass", 64'(d.pass), 64'd1);
        check("basic_err",  64'(d.err),  64'd0);
        check("basic_cyc",  64'(d.cyc),  64'(start_cyc[0] + 12));
`ifdef BLOCK_ARB_LEN_EN
        check("basic_len",  64'(d.len),  64'd9);
`endif

        // Unbalanced.
        nd = dq.size();
        send(1, "end begin", -1, 0);
        wait_done(nd + 1);
        d = get_done(nd);
        check("unbal_id",   64'(d.id),   64'd1);
        check("unbal_pass", 64'(d.pass), 64'd0);
        check("unbal_err",  64'(d.err),  64'd0);

        // Case-insensitive.
        nd = dq.size();
        send(2, "BeGiN eNd", -1, 0);
        wait_done(nd + 1);
        d = get_done(nd);
        check("case_id",   64'(d.id),   64'd2);
        check("case_pass", 64'(d.pass), 64'd1);

        // Underrun: three-cycle gap after "beg".
        nd = dq.size();
        send(3, "begin end", 3, 3);
        wait_done(nd + 1);
        d = get_done(nd);
        check("under_id",   64'(d.id),   64'd3);
        check("under_err",  64'(d.err),  64'd1);
        check("under_pass", 64'(d.pass), 64'd0);
`ifdef BLOCK_ARB_LEN_EN
        check("under_len",  64'(d.len),  64'd9);
`endif

        // Reset in the middle of a stream aborts silently.
        nd = dq.size();
        @(negedge clk);
        req_valid[1]    = 1'b1;
        req_data[15:8]  = "b";
        req_last[1]     = 1'b0;
        repeat (3) @(negedge clk);
        reset = 1'b1;
        #1;
        check("abort_ready",     64'(req_ready),  64'h0);
        check("abort_chk_reset", 64'(chk_reset),  64'd1);
        check("abort_chk_in",    64'(chk_in),     64'h20);
        @(negedge clk);
        #1;
        check("abort_ready2",     64'(req_ready), 64'h0);
        check("abort_chk_reset2", 64'(chk_reset), 64'd1);
        req_valid[1] = 1'b0;
        reset        = 1'b0;
        repeat (20) @(negedge clk);
        check("abort_no_done", 64'(dq.size()), 64'(nd));

        send(0, "begin end", -1, 0);
        wait_done(nd + 1);
        d = get_done(nd);
        check("post_abort_id",   64'(d.id),   64'd0);
        check("post_abort_pass", 64'(d.pass), 64'd1);
        check("post_abort_err",  64'(d.err),  64'd0);

        check("ready_onehot", 64'(onehot_bad), 64'd0);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
